// File: rtl/ram_pattern_sequencer.sv
// Purpose: writes ~addr to every RAM location, reads all back, counts mismatches.
// Latency: one pass takes 2*DEPTH+READ_LATENCY cycles from start to the done pulse.
// Backpressure: none; start is ignored while busy or during the done cycle.
module ram_pattern_sequencer #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_n;

  // Issued-read flag aligned with ram_address, then READ_LATENCY stages
  // that track the address until its data is on ram_q.
  logic                  rd_vld, rd_vld_n;
  logic [READ_LATENCY-1:0] dl_vld;
  logic [ADDR_WIDTH-1:0] dl_addr [READ_LATENCY];

  logic                  busy_n, done_n, pass_n, wren_n;
  logic [ADDR_WIDTH:0]   err_n;
  logic [ADDR_WIDTH-1:0] first_n, addr_n;
  logic [DATA_WIDTH-1:0] data_n;

  logic                  cmp_vld;
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic                  mismatch;
  logic [ADDR_WIDTH:0]   err_acc;
  logic [ADDR_WIDTH-1:0] first_acc;

  // Test pattern: inverted address, zero-extended or truncated to the data width.
  function automatic logic [DATA_WIDTH-1:0] expected(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] inv;
    inv = ~a;
    return DATA_WIDTH'(inv);
  endfunction

  // Checker: compare the oldest delay-line entry against the returned RAM data.
  always_comb begin
    cmp_vld   = dl_vld[READ_LATENCY-1];
    cmp_addr  = dl_addr[READ_LATENCY-1];
    mismatch  = cmp_vld && (ram_q != expected(cmp_addr));
    err_acc   = err_count + (ADDR_WIDTH+1)'(mismatch);
    first_acc = (mismatch && (err_count == '0)) ? cmp_addr : first_err_addr;
  end

  // Next-state and next-output logic for the pass sequencer.
  always_comb begin
    state_n  = state;
    busy_n   = busy;
    done_n   = 1'b0;
    pass_n   = pass;
    err_n    = err_acc;
    first_n  = first_acc;
    wren_n   = ram_wren;
    addr_n   = ram_address;
    data_n   = ram_data;
    rd_vld_n = rd_vld;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_WRITE;
          busy_n  = 1'b1;
          pass_n  = 1'b0;
          err_n   = '0;
          first_n = '0;
          wren_n  = 1'b1;
          addr_n  = '0;
          data_n  = expected('0);
        end
      end
      S_WRITE: begin
        if (ram_address == LAST_ADDR) begin
          state_n  = S_READ;
          wren_n   = 1'b0;
          addr_n   = '0;
          rd_vld_n = 1'b1;
        end else begin
          addr_n = ram_address + 1'b1;
          data_n = expected(ram_address + 1'b1);
        end
      end
      S_READ: begin
        if (ram_address == LAST_ADDR) begin
          state_n  = S_DRAIN;
          rd_vld_n = 1'b0;
        end else begin
          addr_n = ram_address + 1'b1;
        end
      end
      S_DRAIN: begin
        // The final compare retires on this edge; fold it into pass.
        if (cmp_vld && (cmp_addr == LAST_ADDR)) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          pass_n  = (err_acc == '0);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, output registers and the read-tracking delay line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      ram_wren       <= 1'b0;
      ram_address    <= '0;
      ram_data       <= '0;
      rd_vld         <= 1'b0;
      dl_vld         <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dl_addr[i] <= '0;
      end
    end else begin
      state          <= state_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      err_count      <= err_n;
      first_err_addr <= first_n;
      ram_wren       <= wren_n;
      ram_address    <= addr_n;
      ram_data       <= data_n;
      rd_vld         <= rd_vld_n;
      dl_vld[0]      <= rd_vld;
      dl_addr[0]     <= ram_address;
      for (int i = 1; i < READ_LATENCY; i++) begin
        dl_vld[i]  <= dl_vld[i-1];
        dl_addr[i] <= dl_addr[i-1];
      end
    end
  end

endmodule

// File: tb/tb_ram_pattern_sequencer.sv
// Purpose: directed bench for ram_pattern_sequencer with behavioural RAM models.
// Latency: two DUTs, READ_LATENCY 1 and 2, share start/reset.
// Backpressure: not applicable.
module tb_ram_pattern_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fault = 0;   // 0 ideal, 1 q[0] stuck at 0, 2 address 5 reads 0
  bit sel = 1'b0;  // 0 watches the latency-1 DUT, 1 the latency-2 DUT

  // Latency-1 DUT and RAM
  logic       busy1, done1, pass1, wren1;
  logic [4:0] err1;
  logic [3:0] ferr1, addr1, data1, q1;
  // Latency-2 DUT and RAM
  logic       busy2, done2, pass2, wren2;
  logic [4:0] err2;
  logic [3:0] ferr2, addr2, data2, q2;

  ram_pattern_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_addr(ferr1), .ram_wren(wren1), .ram_address(addr1),
    .ram_data(data1), .ram_q(q1)
  );

  ram_pattern_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_addr(ferr2), .ram_wren(wren2), .ram_address(addr2),
    .ram_data(data2), .ram_q(q2)
  );

  function automatic logic [3:0] corrupt(input logic [3:0] q, input logic [3:0] a);
    case (fault)
      1: return q & 4'hE;
      2: return (a == 4'd5) ? 4'h0 : q;
      default: return q;
    endcase
  endfunction

  logic [3:0] mem1 [16];
  logic [3:0] mem2 [16];
  logic [3:0] q1a, ra1, q2a, q2b, ra2a, ra2b;

  // Latency-1 RAM model
  always @(posedge clk) begin
    if (wren1) mem1[addr1] <= data1;
    q1a <= mem1[addr1];
    ra1 <= addr1;
  end
  assign q1 = corrupt(q1a, ra1);

  // Latency-2 RAM model
  always @(posedge clk) begin
    if (wren2) mem2[addr2] <= data2;
    q2a  <= mem2[addr2];
    ra2a <= addr2;
    q2b  <= q2a;
    ra2b <= ra2a;
  end
  assign q2 = corrupt(q2b, ra2b);

  // Observed DUT selected by sel
  logic       m_busy, m_done, m_pass, m_wren;
  logic [4:0] m_err;
  logic [3:0] m_ferr, m_addr, m_data;
  assign m_busy = sel ? busy2 : busy1;
  assign m_done = sel ? done2 : done1;
  assign m_pass = sel ? pass2 : pass1;
  assign m_wren = sel ? wren2 : wren1;
  assign m_err  = sel ? err2  : err1;
  assign m_ferr = sel ? ferr2 : ferr1;
  assign m_addr = sel ? addr2 : addr1;
  assign m_data = sel ? data2 : data1;

  // Pass observations gathered by watch_pass
  int rec_done_cyc, rec_done_cnt, rec_busy_bad, rec_wr_bad, rec_rd_bad;

  // Starts a pass at edge 0 and records per-cycle behaviour of the selected DUT.
  task automatic watch_pass(input bit repulse, input int rl);
    logic [3:0] n4;
    rec_done_cyc = -1; rec_done_cnt = 0;
    rec_busy_bad = 0;  rec_wr_bad = 0; rec_rd_bad = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 32 + rl + 5; n++) begin
      @(negedge clk);
      n4 = 4'(n);
      if (n < 16) begin
        if (!(m_wren === 1'b1 && m_addr === n4 && m_data === ~n4)) rec_wr_bad++;
      end else if (n < 32) begin
        if (!(m_wren === 1'b0 && m_addr === n4)) rec_rd_bad++;
      end
      if (m_busy !== (n < 32 + rl)) rec_busy_bad++;
      if (m_done === 1'b1) begin
        rec_done_cnt++;
        rec_done_cyc = n;
      end
      start = repulse && (n == 3 || n == 20);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (m_busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", m_busy); else passed++;
    checks++; if (m_done !== 1'b0) $display("FAIL reset_done got %0b want 0", m_done); else passed++;
    checks++; if (m_pass !== 1'b0) $display("FAIL reset_pass got %0b want 0", m_pass); else passed++;
    checks++; if (m_err !== 5'd0) $display("FAIL reset_err got %0d want 0", m_err); else passed++;
    checks++; if (m_wren !== 1'b0 || m_addr !== 4'd0 || m_data !== 4'd0)
      $display("FAIL reset_ram got wren=%0b addr=%0d data=%0h want 0/0/0", m_wren, m_addr, m_data);
    else passed++;
    checks++; if (busy2 !== 1'b0 || wren2 !== 1'b0) $display("FAIL reset_dut2 got busy=%0b wren=%0b want 0/0", busy2, wren2); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_ideal(input string name, input bit repulse);
    fault = 0; sel = 1'b0;
    watch_pass(repulse, 1);
    checks++; if (rec_wr_bad != 0) $display("FAIL %s_writes got %0d bad cycles want 0", name, rec_wr_bad); else passed++;
    checks++; if (rec_rd_bad != 0) $display("FAIL %s_reads got %0d bad cycles want 0", name, rec_rd_bad); else passed++;
    checks++; if (rec_busy_bad != 0) $display("FAIL %s_busy got %0d bad cycles want 0", name, rec_busy_bad); else passed++;
    checks++; if (rec_done_cnt != 1 || rec_done_cyc != 33)
      $display("FAIL %s_done got count=%0d cycle=%0d want 1/33", name, rec_done_cnt, rec_done_cyc);
    else passed++;
    checks++; if (m_pass !== 1'b1 || m_err !== 5'd0 || m_ferr !== 4'd0)
      $display("FAIL %s_result got pass=%0b err=%0d first=%0d want 1/0/0", name, m_pass, m_err, m_ferr);
    else passed++;
  endtask

  task automatic test_stuck_bit;
    fault = 1; sel = 1'b0;
    watch_pass(1'b0, 1);
    checks++; if (rec_done_cnt != 1 || rec_done_cyc != 33)
      $display("FAIL stuck_done got count=%0d cycle=%0d want 1/33", rec_done_cnt, rec_done_cyc);
    else passed++;
    checks++; if (m_pass !== 1'b0 || m_err !== 5'd8 || m_ferr !== 4'd0)
      $display("FAIL stuck_result got pass=%0b err=%0d first=%0d want 0/8/0", m_pass, m_err, m_ferr);
    else passed++;
  endtask

  task automatic test_single_addr;
    fault = 2; sel = 1'b0;
    watch_pass(1'b0, 1);
    checks++; if (rec_done_cyc != 33) $display("FAIL addr5_done got cycle=%0d want 33", rec_done_cyc); else passed++;
    checks++; if (m_pass !== 1'b0 || m_err !== 5'd1 || m_ferr !== 4'd5)
      $display("FAIL addr5_result got pass=%0b err=%0d first=%0d want 0/1/5", m_pass, m_err, m_ferr);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int dones;
    fault = 0; sel = 1'b0; dones = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 7) reset = 1'b1;
    end
    @(negedge clk);  // cycle 8
    checks++; if (m_wren !== 1'b0 || m_busy !== 1'b0)
      $display("FAIL midrst_outputs got wren=%0b busy=%0b want 0/0", m_wren, m_busy);
    else passed++;
    checks++; if (m_addr !== 4'd0 || m_data !== 4'd0 || m_err !== 5'd0)
      $display("FAIL midrst_regs got addr=%0d data=%0h err=%0d want 0/0/0", m_addr, m_data, m_err);
    else passed++;
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (m_done === 1'b1 || done2 === 1'b1) dones++;
    end
    checks++; if (dones != 0) $display("FAIL midrst_nodone got %0d pulses want 0", dones); else passed++;
    watch_pass(1'b0, 1);
    checks++; if (rec_done_cyc != 33 || m_pass !== 1'b1 || m_err !== 5'd0)
      $display("FAIL midrst_rerun got cycle=%0d pass=%0b err=%0d want 33/1/0", rec_done_cyc, m_pass, m_err);
    else passed++;
  endtask

  task automatic test_latency2;
    fault = 0; sel = 1'b1;
    watch_pass(1'b0, 2);
    checks++; if (rec_wr_bad != 0 || rec_rd_bad != 0)
      $display("FAIL lat2_access got wr_bad=%0d rd_bad=%0d want 0/0", rec_wr_bad, rec_rd_bad);
    else passed++;
    checks++; if (rec_busy_bad != 0) $display("FAIL lat2_busy got %0d bad cycles want 0", rec_busy_bad); else passed++;
    checks++; if (rec_done_cnt != 1 || rec_done_cyc != 34)
      $display("FAIL lat2_done got count=%0d cycle=%0d want 1/34", rec_done_cnt, rec_done_cyc);
    else passed++;
    checks++; if (m_pass !== 1'b1 || m_err !== 5'd0 || m_ferr !== 4'd0)
      $display("FAIL lat2_result got pass=%0b err=%0d first=%0d want 1/0/0", m_pass, m_err, m_ferr);
    else passed++;
    sel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_ideal("ideal", 1'b0);
    test_stuck_bit;
    test_single_addr;
    test_ideal("repulse", 1'b1);
    test_reset_mid;
    test_latency2;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
